// File: rtl/logic_op_arbiter.sv
// logic_op_arbiter: four-port round-robin arbiter feeding a shared registered bitwise logic unit
module logic_op_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req_valid,
  input  logic [11:0]        req_op,
  input  logic [4*WIDTH-1:0] req_a,
  input  logic [4*WIDTH-1:0] req_b,
  output logic [3:0]         req_ready,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [1:0]         resp_id,
  output logic [WIDTH-1:0]   resp_data,
  output logic               resp_err,
  output logic               busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nxt;
  logic [1:0] ptr, gid, idx, id_q;
  logic found, accept;
  logic [2:0] op_q;
  logic [WIDTH-1:0] a_q, b_q, res;
  always_comb begin
    gid = ptr;
    idx = ptr;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req_valid[idx]) begin
        gid = idx;
        found = 1'b1;
      end
    end
  end
  assign accept = state == IDLE && found;
  assign req_ready = accept ? 4'b0001 << gid : 4'b0000;
  assign busy = state != IDLE;
  assign res = op_q == 3'd0 ? a_q & b_q :
               op_q == 3'd1 ? a_q | b_q :
               op_q == 3'd2 ? ~a_q :
               op_q == 3'd3 ? ~(a_q & b_q) :
               op_q == 3'd4 ? ~(a_q | b_q) :
               op_q == 3'd5 ? a_q ^ b_q :
               op_q == 3'd6 ? ~(a_q ^ b_q) : '0;
  always_comb begin
    state_nxt = state == IDLE ? (accept ? EXEC : IDLE) :
                state == EXEC ? RESP :
                (resp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      id_q <= '0;
      resp_valid <= 1'b0;
      resp_id <= '0;
      resp_data <= '0;
      resp_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q <= req_op[3*gid +: 3];
        a_q <= req_a[WIDTH*gid +: WIDTH];
        b_q <= req_b[WIDTH*gid +: WIDTH];
        id_q <= gid;
        ptr <= gid + 2'd1;
      end
      if (state == EXEC) begin
        resp_data <= res;
        resp_err <= &op_q;
        resp_id <= id_q;
        resp_valid <= 1'b1;
      end else if (state == RESP && resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_logic_op_arbiter.sv
// tb_logic_op_arbiter: vector table, corner sequences and random traffic against a truth-table model
module tb_logic_op_arbiter;
  localparam int WIDTH = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req_valid = '0;
  logic [11:0] req_op;
  logic [4*WIDTH-1:0] req_a, req_b;
  logic [3:0] req_ready;
  logic resp_valid;
  logic resp_ready = 1'b1;
  logic [1:0] resp_id;
  logic [WIDTH-1:0] resp_data;
  logic resp_err, busy;
  logic [2:0] t_op [4];
  logic [WIDTH-1:0] t_a [4];
  logic [WIDTH-1:0] t_b [4];
  logic [3:0] tt [8];
  int n_cmp = 0;
  int n_err = 0;
  int m_ptr = 0;
  typedef struct {
    logic [1:0] id;
    logic [2:0] op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] d;
    logic e;
  } vec_t;
  vec_t vt [9];
  always #5 clk = ~clk;
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      req_op[3*i +: 3] = t_op[i];
      req_a[WIDTH*i +: WIDTH] = t_a[i];
      req_b[WIDTH*i +: WIDTH] = t_b[i];
    end
  end
  logic_op_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_err(resp_err), .busy(busy)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask
  function automatic logic [WIDTH:0] ref_op(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    logic [3:0] row;
    r = '0;
    if (op == 3'd7) return {1'b1, {WIDTH{1'b0}}};
    row = tt[op];
    for (int i = 0; i < WIDTH; i++) r[i] = row[{a[i], b[i]}];
    return {1'b0, r};
  endfunction
  function automatic int winner(input logic [3:0] v);
    for (int k = 0; k < 4; k++) if (v[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return -1;
  endfunction
  task automatic transact(input int hold, input bit drop, output logic [1:0] o_id, output logic [WIDTH:0] got);
    int w;
    logic [WIDTH:0] exp;
    logic [1:0] sid;
    logic [WIDTH-1:0] sdata;
    logic serr;
    #1;
    w = winner(req_valid);
    chk("grant", 32'(req_ready), w < 0 ? 32'd0 : 32'(1) << w);
    o_id = '0;
    got = '0;
    if (w < 0) return;
    exp = ref_op(t_op[w], t_a[w], t_b[w]);
    @(negedge clk);
    chk("exec_busy", 32'(busy), 1);
    chk("exec_ready", 32'(req_ready), 0);
    chk("exec_valid", 32'(resp_valid), 0);
    if (drop) req_valid[w] = 1'b0;
    resp_ready = (hold == 0);
    @(negedge clk);
    chk("resp_valid", 32'(resp_valid), 1);
    chk("resp_id", 32'(resp_id), 32'(w));
    chk("resp_data", 32'(resp_data), 32'(exp[WIDTH-1:0]));
    chk("resp_err", 32'(resp_err), 32'(exp[WIDTH]));
    sid = resp_id;
    sdata = resp_data;
    serr = resp_err;
    o_id = resp_id;
    got = {resp_err, resp_data};
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 32'(resp_valid), 1);
      chk("hold_id", 32'(resp_id), 32'(sid));
      chk("hold_data", 32'(resp_data), 32'(sdata));
      chk("hold_err", 32'(resp_err), 32'(serr));
      chk("hold_busy", 32'(busy), 1);
      chk("hold_ready", 32'(req_ready), 0);
      if (h == hold - 1) resp_ready = 1'b1;
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("done_valid", 32'(resp_valid), 0);
    chk("done_busy", 32'(busy), 0);
    m_ptr = (w + 1) % 4;
  endtask
  initial begin
    logic [1:0] id;
    logic [WIDTH:0] got;
    logic [WIDTH-1:0] vd [8];
    int w;
    tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0011; tt[3] = 4'b0111;
    tt[4] = 4'b0001; tt[5] = 4'b0110; tt[6] = 4'b1001; tt[7] = 4'b0000;
    vd[0] = 8'h05; vd[1] = 8'hAF; vd[2] = 8'h5A; vd[3] = 8'hFA;
    vd[4] = 8'h50; vd[5] = 8'hAA; vd[6] = 8'h55; vd[7] = 8'h00;
    vt[0] = '{2'd0, 3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0};
    for (int i = 0; i < 8; i++) vt[i+1] = '{2'd2, 3'(i), 8'hA5, 8'h0F, vd[i], i == 7};
    for (int i = 0; i < 4; i++) begin
      t_op[i] = '0;
      t_a[i] = '0;
      t_b[i] = '0;
    end
    @(negedge clk);
    chk("rst_valid", 32'(resp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_id", 32'(resp_id), 0);
    chk("rst_data", 32'(resp_data), 0);
    chk("rst_err", 32'(resp_err), 0);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      t_op[vt[i].id] = vt[i].op;
      t_a[vt[i].id] = vt[i].a;
      t_b[vt[i].id] = vt[i].b;
      req_valid = 4'b0001 << vt[i].id;
      transact(0, 1'b1, id, got);
      chk("vec_data", 32'(got[WIDTH-1:0]), 32'(vt[i].d));
      chk("vec_err", 32'(got[WIDTH]), 32'(vt[i].e));
    end
    rst = 1'b1;
    m_ptr = 0;
    for (int i = 0; i < 4; i++) begin
      t_op[i] = 3'($urandom_range(0, 7));
      t_a[i] = WIDTH'($urandom);
      t_b[i] = WIDTH'($urandom);
    end
    req_valid = 4'b1111;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      transact(0, 1'b0, id, got);
      chk("rot_id", 32'(id), 32'(i % 4));
    end
    req_valid = 4'b0010;
    transact(0, 1'b1, id, got);
    req_valid = 4'b1010;
    transact(0, 1'b1, id, got);
    chk("rr_first", 32'(id), 3);
    transact(0, 1'b1, id, got);
    chk("rr_second", 32'(id), 1);
    req_valid = 4'b0010;
    transact(0, 1'b1, id, got);
    req_valid = 4'b1111;
    #1;
    @(negedge clk);
    chk("exec_pre_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk("exec_rst_valid", 32'(resp_valid), 0);
    chk("exec_rst_busy", 32'(busy), 0);
    m_ptr = 0;
    @(negedge clk);
    rst = 1'b0;
    transact(0, 1'b0, id, got);
    chk("exec_rst_next", 32'(id), 0);
    #1;
    @(negedge clk);
    @(negedge clk);
    chk("resp_pre_valid", 32'(resp_valid), 1);
    rst = 1'b1;
    #1;
    chk("resp_rst_valid", 32'(resp_valid), 0);
    chk("resp_rst_busy", 32'(busy), 0);
    chk("resp_rst_data", 32'(resp_data), 0);
    m_ptr = 0;
    @(negedge clk);
    rst = 1'b0;
    transact(0, 1'b0, id, got);
    chk("resp_rst_next", 32'(id), 0);
    transact(5, 1'b0, id, got);
    req_valid = 4'b0100;
    #1;
    chk("cancel_grant", 32'(req_ready), 32'h4);
    req_valid = 4'b0000;
    #1;
    chk("cancel_ready", 32'(req_ready), 0);
    @(negedge clk);
    chk("cancel_busy", 32'(busy), 0);
    chk("cancel_valid", 32'(resp_valid), 0);
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 4; i++) begin
        t_op[i] = 3'($urandom_range(0, 7));
        t_a[i] = WIDTH'($urandom);
        t_b[i] = WIDTH'($urandom);
      end
      req_valid = 4'($urandom_range(1, 15));
      w = winner(req_valid);
      transact($urandom_range(0, 2), 1'b0, id, got);
      chk("rand_id", 32'(id), 32'(w));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/logic_op_arbiter.md
# logic_op_arbiter

Shared bitwise logic unit with a four-port round-robin arbiter in front of it. Four requesters each present an opcode and two WIDTH-bit operands with a valid/ready handshake. The block grants one requester at a time and evaluates AND/OR/NOT/NAND/NOR/XOR/XNOR on the latched operands. It returns a registered result tagged with the requester ID through a valid/ready response channel. It sits between the gate-level logic primitives and any client that needs logic operations without owning a private gate array.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits (legal 1..32)

Ports:
- clk  input  1  single clock, rising-edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  4  per-requester request valid; bit i = requester i
- req_op  input  12  opcodes, requester i on bits [3i+2:3i]
- req_a  input  4*WIDTH  operand A, requester i on bits [WIDTH*i+WIDTH-1:WIDTH*i]
- req_b  input  4*WIDTH  operand B, same packing as req_a
- req_ready  output  4  one-hot accept strobe; at most one bit high
- resp_valid  output  1  response available
- resp_ready  input  1  response consumer ready
- resp_id  output  2  requester index of current response
- resp_data  output  WIDTH  operation result
- resp_err  output  1  high when the opcode was reserved
- busy  output  1  high whenever state != IDLE

## Operation
- Opcodes: 000 AND, 001 OR, 010 NOT (of A; B ignored), 011 NAND, 100 NOR, 101 XOR, 110 XNOR, 111 reserved -> resp_data = 0, resp_err = 1.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready is combinational. It drives a one-hot grant to the round-robin winner among set req_valid bits, or 0 if no request is valid.
  - On the edge where req_valid[g] && req_ready[g], latch op/a/b of requester g and g itself, then go to EXEC.
- EXEC:
  - Compute the result from the latched operands.
  - Register resp_data, resp_err and resp_id, set resp_valid, then go to RESP.
  - req_ready = 0.
- RESP:
  - resp_valid, resp_id, resp_data and resp_err are held stable until resp_valid && resp_ready.
  - On that edge, clear resp_valid and go to IDLE.
  - req_ready = 0.
- Round-robin:
  - A 2-bit pointer ptr marks the highest-priority requester.
  - Search order is ptr, ptr+1, ptr+2, ptr+3, mod 4.
  - On acceptance of requester g, ptr <= (g+1) mod 4. ptr does not change otherwise.
- Requesters not granted keep their request pending. The block never drops a valid request; requesters must hold req_valid and operands until accepted.
- Result width is exactly WIDTH; no carries or extension. NOT operates on all WIDTH bits of A.

## Timing
- Reset (async assert, sync-deassert-safe):
  - state = IDLE, ptr = 0.
  - resp_valid = 0, resp_id = 0, resp_data = 0, resp_err = 0.
  - busy = 0, req_ready = 0 unless a request is valid.
- Latency: acceptance edge T -> resp_valid high after edge T+1, i.e. visible in cycle T+1.
- With resp_ready held high, the response completes at edge T+2. Next acceptance is no earlier than edge T+3, so peak throughput is 1 op / 3 cycles.
- Backpressure: resp_ready low holds RESP indefinitely with all response outputs stable. No new grant is issued while busy.
- Simultaneous events:
  - req_valid rising in RESP is not accepted until IDLE.
  - With all four requesting continuously, grants rotate in the order 0,1,2,3,0,... starting from ptr.
- Reset mid-operation (EXEC or RESP): the in-flight op is discarded with no response, and all reset values apply immediately.
- req_valid dropping while in IDLE before the edge cancels that request with no side effect.

## Test plan
- Reset, then requester 0 sends op=000, A=0xF0, B=0x3C.
  - req_ready=0001 in the same cycle.
  - resp_valid two edges later with resp_id=0, resp_data=0x30, resp_err=0.
- Sweep all opcodes on requester 2 with A=0xA5, B=0x0F, resp_ready high.
  - Required results: AND 0x05, OR 0xAF, NOT 0x5A, NAND 0xFA, NOR 0x50, XOR 0xAA, XNOR 0x55.
  - op=111 -> resp_data=0x00, resp_err=1.
- All four req_valid held high from reset, 8 operations.
  - resp_id sequence 0,1,2,3,0,1,2,3.
  - Never two req_ready bits high together.
- Requesters 1 and 3 valid with ptr=2 (after a grant to requester 1): grant goes to 3 first, then 1.
- resp_ready low for 5 cycles after resp_valid.
  - Outputs stable and busy=1 throughout.
  - req_ready=0000 despite req_valid=1111.
  - Completes on the cycle resp_ready rises.
- Assert rst during EXEC and separately during RESP.
  - resp_valid=0 and busy=0 immediately.
  - ptr=0, so the next grant with all valid goes to requester 0.
